// File: rtl/if_fetch.sv
// Instruction fetch stage: single-outstanding request FSM with redirect handling.
// Optional static branch prediction is enabled by defining STATIC_BPRED_EN.
module if_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h1C00_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  input  logic                  br_redirect,
  input  logic [ADDR_WIDTH-1:0] br_target,
  output logic                  inst_req,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  inst_addr_ok,
  input  logic                  inst_data_ok,
  input  logic [31:0]           inst_rdata,
  input  logic                  ns_ready,
  output logic                  ts_valid,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [31:0]           out_inst,
  output logic                  out_branch,
  output logic [ADDR_WIDTH-1:0] out_branch_addr
);

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_CANCEL = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   pc_r;
  logic [ADDR_WIDTH-1:0]   pc_nxt;
  logic [ADDR_WIDTH-1:0]   next_pc;
  logic [ADDR_WIDTH-1:0]   redirect_raw;
  logic [ADDR_WIDTH-1:0]   redirect_pc;
  logic                    redirect;
  logic                    capture;
  logic                    pred_taken;
  logic [ADDR_WIDTH-1:0]   pred_addr;

  assign redirect     = flush | br_redirect;
  assign redirect_raw = flush ? flush_pc : br_target;
  assign redirect_pc  = {redirect_raw[ADDR_WIDTH-1:2], 2'b00};
  assign next_pc      = out_branch ? out_branch_addr : (pc_r + PC_STEP);
  assign capture      = (state == S_WAIT) & inst_data_ok & ~redirect;

  assign inst_req  = (state == S_REQ) & ~rst;
  assign inst_addr = pc_r;
  assign ts_valid  = (state == S_HOLD) & ~redirect & ~rst;

`ifdef STATIC_BPRED_EN
  logic                  is_b;
  logic [ADDR_WIDTH-1:0] br_offset;

  assign is_b       = (inst_rdata[31:27] == 5'b01010);
  assign br_offset  = {{(ADDR_WIDTH-28){inst_rdata[9]}}, inst_rdata[9:0], inst_rdata[25:10], 2'b00};
  assign pred_taken = is_b;
  assign pred_addr  = is_b ? (pc_r + br_offset) : (pc_r + PC_STEP);
`else
  assign pred_taken = 1'b0;
  assign pred_addr  = pc_r + PC_STEP;
`endif

  // Next-state and next-pc selection; redirects always retarget pc_r.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_r;
    case (state)
      S_REQ: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          state_nxt = inst_addr_ok ? S_CANCEL : S_REQ;
        end else if (inst_addr_ok) begin
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          state_nxt = inst_data_ok ? S_REQ : S_CANCEL;
        end else if (inst_data_ok) begin
          state_nxt = S_HOLD;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          state_nxt = S_REQ;
        end else if (ns_ready) begin
          pc_nxt    = next_pc;
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_HOLD;
        end
      end
      S_CANCEL: begin
        // The abandoned response still has to drain before a new request goes out.
        if (redirect) begin
          pc_nxt = redirect_pc;
        end else begin
          pc_nxt = pc_r;
        end
        if (inst_data_ok) begin
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_CANCEL;
        end
      end
      default: begin
        state_nxt = S_REQ;
        pc_nxt    = pc_r;
      end
    endcase
  end

  // State and pc registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      pc_r  <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc_r  <= pc_nxt;
    end
  end

  // Fetched packet, captured once per accepted response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pc          <= RESET_PC;
      out_inst        <= 32'h0000_0000;
      out_branch      <= 1'b0;
      out_branch_addr <= RESET_PC + PC_STEP;
    end else if (capture) begin
      out_pc          <= pc_r;
      out_inst        <= inst_rdata;
      out_branch      <= pred_taken;
      out_branch_addr <= pred_addr;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed stimulus, transaction-level model
// compared every cycle, plus literal expectations at key points.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        ns_ready;
  logic        ts_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_branch;
  logic [31:0] out_branch_addr;

  int n_chk  = 0;
  int n_pass = 0;

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .br_redirect     (br_redirect),
    .br_target       (br_target),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata      (inst_rdata),
    .ns_ready        (ns_ready),
    .ts_valid        (ts_valid),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_branch      (out_branch),
    .out_branch_addr (out_branch_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%08h required=%08h", name, act, exp);
  endtask

  // Model: what is outstanding, whether its answer is unwanted, and the held packet.
  logic [31:0] m_fetch_pc;
  logic        m_pending;
  logic        m_drop;
  logic        m_pkt_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_br;
  logic [31:0] m_baddr;
  logic [31:0] acc_q[$];

  function automatic logic m_is_br(input logic [31:0] inst);
`ifdef STATIC_BPRED_EN
    return (inst[31:26] == 6'b010100) || (inst[31:26] == 6'b010101);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc, input logic [31:0] inst);
    logic [25:0] imm;
    int          off;
    imm = {inst[9:0], inst[25:10]};
    off = $signed(imm) * 4;
    if (m_is_br(inst)) return 32'(pc + off);
    else return pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_fetch_pc  = 32'h1C00_0000;
    m_pending   = 1'b0;
    m_drop      = 1'b0;
    m_pkt_valid = 1'b0;
    m_pc        = 32'h1C00_0000;
    m_inst      = 32'h0000_0000;
    m_br        = 1'b0;
    m_baddr     = 32'h1C00_0004;
  endtask

  task automatic model_step();
    logic        redir;
    logic [31:0] tgt;
    redir = flush | br_redirect;
    tgt   = (flush ? flush_pc : br_target) & ~32'd3;
    if (m_pkt_valid) begin
      if (redir) begin
        m_pkt_valid = 1'b0;
        m_fetch_pc  = tgt;
      end else if (ns_ready) begin
        m_pkt_valid = 1'b0;
        m_fetch_pc  = m_br ? m_baddr : m_pc + 32'd4;
      end
    end else if (m_pending) begin
      if (inst_data_ok) begin
        if (!m_drop && !redir) begin
          m_pkt_valid = 1'b1;
          m_pc        = m_fetch_pc;
          m_inst      = inst_rdata;
          m_br        = m_is_br(inst_rdata);
          m_baddr     = m_target(m_fetch_pc, inst_rdata);
        end
        m_pending = 1'b0;
        m_drop    = 1'b0;
      end else if (redir) begin
        m_drop = 1'b1;
      end
      if (redir) m_fetch_pc = tgt;
    end else begin
      if (inst_addr_ok) begin
        acc_q.push_back(m_fetch_pc);
        m_pending = 1'b1;
        m_drop    = redir;
      end
      if (redir) m_fetch_pc = tgt;
    end
  endtask

  // Per-cycle comparison against the model, then advance it over the coming edge.
  always @(negedge clk) begin
    logic exp_req;
    logic exp_tsv;
    if (rst) model_reset();
    exp_req = !rst && !m_pending && !m_pkt_valid;
    exp_tsv = !rst && m_pkt_valid && !flush && !br_redirect;
    chk("m_inst_req", 32'(inst_req), 32'(exp_req));
    if (exp_req) chk("m_inst_addr", inst_addr, m_fetch_pc);
    chk("m_ts_valid", 32'(ts_valid), 32'(exp_tsv));
    chk("m_out_pc", out_pc, m_pc);
    chk("m_out_inst", out_inst, m_inst);
    chk("m_out_branch", 32'(out_branch), 32'(m_br));
    chk("m_out_baddr", out_branch_addr, m_baddr);
    if (!rst) model_step();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic fetch(input logic [31:0] d);
    inst_addr_ok = 1'b1; inst_data_ok = 1'b0; ns_ready = 1'b0;
    cyc();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = d;
    cyc();
    inst_data_ok = 1'b0;
    settle();
    chk("fetch_ts_valid", 32'(ts_valid), 32'd1);
  endtask

  task automatic release_pkt();
    ns_ready = 1'b1;
    cyc();
    ns_ready = 1'b0;
    settle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; flush_pc = 32'h0; br_redirect = 1'b0; br_target = 32'h0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0; ns_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_inst_req", 32'(inst_req), 32'd0);
    chk("rst_ts_valid", 32'(ts_valid), 32'd0);
    chk("rst_baddr", out_branch_addr, 32'h1C00_0004);

    // Back-to-back fetches with everything ready.
    rst = 1'b0; inst_addr_ok = 1'b1; inst_data_ok = 1'b1; ns_ready = 1'b1;
    inst_rdata = 32'hA5A5_0000;
    settle();
    chk("first_req", 32'(inst_req), 32'd1);
    chk("first_addr", inst_addr, 32'h1C00_0000);
    for (int i = 0; i < 9; i++) begin
      cyc();
      inst_rdata = 32'hA5A5_0001 + 32'(i);
    end
    chk("acc0", acc_q[0], 32'h1C00_0000);
    chk("acc1", acc_q[1], 32'h1C00_0004);
    chk("acc2", acc_q[2], 32'h1C00_0008);

    // Stall in HOLD for five cycles.
    ns_ready = 1'b0; inst_rdata = 32'hDEAD_BEEF;
    cyc();
    cyc();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    settle();
    for (int i = 0; i < 5; i++) begin
      chk("hold_tsv", 32'(ts_valid), 32'd1);
      chk("hold_req", 32'(inst_req), 32'd0);
      chk("hold_pc", inst_addr, 32'h1C00_000C);
      chk("hold_out_pc", out_pc, 32'h1C00_000C);
      chk("hold_out_inst", out_inst, 32'hDEAD_BEEF);
      cyc();
    end
    release_pkt();

    // Branch redirect while waiting; late response is dropped.
    inst_addr_ok = 1'b1;
    cyc();
    inst_addr_ok = 1'b0; br_redirect = 1'b1; br_target = 32'h1C00_1000;
    cyc();
    br_redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("cancel_req", 32'(inst_req), 32'd0);
      chk("cancel_tsv", 32'(ts_valid), 32'd0);
      cyc();
    end
    inst_data_ok = 1'b1; inst_rdata = 32'h1234_5678;
    cyc();
    inst_data_ok = 1'b0;
    settle();
    chk("redir_req", 32'(inst_req), 32'd1);
    chk("redir_addr", inst_addr, 32'h1C00_1000);
    chk("redir_tsv", 32'(ts_valid), 32'd0);

    // Flush beats branch redirect.
    flush = 1'b1; flush_pc = 32'h1C00_8000; br_redirect = 1'b1; br_target = 32'h1C00_1000;
    cyc();
    flush = 1'b0; br_redirect = 1'b0;
    settle();
    chk("prio_addr", inst_addr, 32'h1C00_8000);

    // Redirect coincident with acceptance, then a second redirect in CANCEL.
    inst_addr_ok = 1'b1; br_redirect = 1'b1; br_target = 32'h1C00_2003;
    cyc();
    inst_addr_ok = 1'b0; br_redirect = 1'b0;
    settle();
    chk("req_cancel", 32'(inst_req), 32'd0);
    flush = 1'b1; flush_pc = 32'h1C00_3000;
    cyc();
    flush = 1'b0;
    settle();
    chk("cancel_redir_req", 32'(inst_req), 32'd0);
    inst_data_ok = 1'b1;
    cyc();
    inst_data_ok = 1'b0;
    settle();
    chk("cancel_exit_addr", inst_addr, 32'h1C00_3000);

    // Redirect together with data_ok in WAIT; target low bits cleared.
    inst_addr_ok = 1'b1;
    cyc();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; br_redirect = 1'b1; br_target = 32'h1C00_4002;
    cyc();
    inst_data_ok = 1'b0; br_redirect = 1'b0;
    settle();
    chk("wait_redir_addr", inst_addr, 32'h1C00_4000);
    chk("wait_redir_tsv", 32'(ts_valid), 32'd0);

    // Flush in HOLD with ns_ready; then address wrap.
    fetch(32'h0000_0001);
    ns_ready = 1'b1; flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    settle();
    chk("hold_flush_mask", 32'(ts_valid), 32'd0);
    cyc();
    ns_ready = 1'b0; flush = 1'b0;
    settle();
    chk("hold_flush_addr", inst_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_0000);
    release_pkt();
    chk("wrap_addr", inst_addr, 32'h0000_0000);

    // Static prediction encodings.
    flush = 1'b1; flush_pc = 32'h1C00_0000;
    cyc();
    flush = 1'b0;
    fetch(32'h5000_0400);
    chk("b_out_pc", out_pc, 32'h1C00_0000);
    chk("b_baddr", out_branch_addr, 32'h1C00_0004);
`ifdef STATIC_BPRED_EN
    chk("b_taken", 32'(out_branch), 32'd1);
`else
    chk("b_taken", 32'(out_branch), 32'd0);
`endif
    release_pkt();
    chk("b_next", inst_addr, 32'h1C00_0004);
    flush = 1'b1; flush_pc = 32'h1C00_0000;
    cyc();
    flush = 1'b0;
    fetch(32'h53FF_FFFF);
`ifdef STATIC_BPRED_EN
    chk("bneg_baddr", out_branch_addr, 32'h1BFF_FFFC);
    release_pkt();
    chk("bneg_next", inst_addr, 32'h1BFF_FFFC);
`else
    chk("bneg_baddr", out_branch_addr, 32'h1C00_0004);
    release_pkt();
    chk("bneg_next", inst_addr, 32'h1C00_0004);
`endif

    // Reset while a request is in flight, stale response afterwards.
    inst_addr_ok = 1'b1;
    cyc();
    inst_addr_ok = 1'b0; rst = 1'b1;
    settle();
    chk("midrst_req", 32'(inst_req), 32'd0);
    chk("midrst_tsv", 32'(ts_valid), 32'd0);
    cyc();
    cyc();
    rst = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hBAD0_BAD0;
    settle();
    chk("post_rst_addr", inst_addr, 32'h1C00_0000);
    cyc();
    inst_data_ok = 1'b0;
    settle();
    chk("stale_req", 32'(inst_req), 32'd1);
    chk("stale_addr", inst_addr, 32'h1C00_0000);
    chk("stale_tsv", 32'(ts_valid), 32'd0);
    fetch(32'h1111_2222);
    chk("post_rst_out_pc", out_pc, 32'h1C00_0000);
    chk("post_rst_out_inst", out_inst, 32'h1111_2222);
    release_pkt();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
